// File: rtl/ir_tx_if.sv
// Frame request/status bundle between an IR transmitter and the logic that feeds it.
// The master supplies the word and start strobe; the slave (ir_tx) returns LED drive and status.
interface ir_tx_if;
  logic [31:0] i_data;
  logic        i_start;
  logic        o_ir_tx;
  logic        o_busy;
  logic        o_done;

  modport master (
    output i_data,
    output i_start,
    input  o_ir_tx,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_data,
    input  i_start,
    output o_ir_tx,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/ir_tx.sv
// NEC-format IR transmitter: leader, 32 pulse-distance bits MSB first, stop mark.
// Define IR_TX_CARRIER_EN to modulate marks with a 50% carrier of CARRIER_DIV clks.
module ir_tx #(
  parameter int unsigned CLK_DIV      = 50,
  parameter int unsigned T_LEAD_MARK  = 9000,
  parameter int unsigned T_LEAD_SPACE = 4500,
  parameter int unsigned T_BIT_MARK   = 560,
  parameter int unsigned T_ZERO_SPACE = 560,
  parameter int unsigned T_ONE_SPACE  = 1690,
  parameter int unsigned CARRIER_DIV  = 1316
) (
  input  logic    clk,
  input  logic    rst_n,
  ir_tx_if.slave  bus
);

  if (CLK_DIV < 1 || CLK_DIV > 65535 ||
      T_LEAD_MARK < 1 || T_LEAD_MARK > 65535 ||
      T_LEAD_SPACE < 1 || T_LEAD_SPACE > 65535 ||
      T_BIT_MARK < 1 || T_BIT_MARK > 65535 ||
      T_ZERO_SPACE < 1 || T_ZERO_SPACE > 65535 ||
      T_ONE_SPACE < 1 || T_ONE_SPACE > 65535 ||
      CARRIER_DIV < 2 || CARRIER_DIV > 65535) begin : g_param_range
    $error("ir_tx: timing parameter outside 16-bit range");
  end

  localparam logic [15:0] TICK_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] LEAD_M_LAST = 16'(T_LEAD_MARK - 1);
  localparam logic [15:0] LEAD_S_LAST = 16'(T_LEAD_SPACE - 1);
  localparam logic [15:0] BIT_M_LAST  = 16'(T_BIT_MARK - 1);
  localparam logic [15:0] ZERO_LAST   = 16'(T_ZERO_SPACE - 1);
  localparam logic [15:0] ONE_LAST    = 16'(T_ONE_SPACE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [15:0] dur_q, dur_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic        ir_q, ir_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick;
  logic        mark_d;
  logic [15:0] dur_last;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    dur_d      = dur_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tick       = (tick_cnt_q == TICK_LAST);

    case (state_q)
      LEAD_MARK:  dur_last = LEAD_M_LAST;
      LEAD_SPACE: dur_last = LEAD_S_LAST;
      BIT_SPACE:  dur_last = shift_q[31] ? ONE_LAST : ZERO_LAST;
      default:    dur_last = BIT_M_LAST;
    endcase

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        dur_d      = '0;
        if (bus.i_start) begin
          shift_d   = bus.i_data;
          bit_cnt_d = '0;
          state_d   = LEAD_MARK;
        end
      end
      DONE: begin
        tick_cnt_d = '0;
        dur_d      = '0;
        state_d    = IDLE;
      end
      default: begin
        // Every timed state lasts a whole number of ticks, so the tick phase never drifts.
        tick_cnt_d = tick ? '0 : tick_cnt_q + 16'd1;
        if (tick) begin
          if (dur_q == dur_last) begin
            dur_d = '0;
            case (state_q)
              LEAD_MARK:  state_d = LEAD_SPACE;
              LEAD_SPACE: state_d = BIT_MARK;
              BIT_MARK:   state_d = BIT_SPACE;
              BIT_SPACE: begin
                shift_d   = {shift_q[30:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 6'd1;
                state_d   = (bit_cnt_q == 6'd31) ? STOP_MARK : BIT_MARK;
              end
              default:    state_d = DONE;
            endcase
          end else begin
            dur_d = dur_q + 16'd1;
          end
        end
      end
    endcase

    mark_d = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

`ifdef IR_TX_CARRIER_EN
  localparam logic [15:0] CAR_LAST = 16'(CARRIER_DIV - 1);
  localparam logic [15:0] CAR_HALF = 16'(CARRIER_DIV / 2);

  logic [15:0] car_q, car_d;

  // Carrier phase restarts high on every entry into a mark state.
  always_comb begin
    car_d = '0;
    if (mark_d && (state_d == state_q)) begin
      car_d = (car_q == CAR_LAST) ? '0 : car_q + 16'd1;
    end
    ir_d = mark_d && (car_d < CAR_HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_q <= '0;
    end else begin
      car_q <= car_d;
    end
  end
`else
  always_comb begin
    ir_d = mark_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      dur_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ir_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      dur_q      <= dur_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ir_q       <= ir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_ir_tx = ir_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

endmodule
